// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb: reservation station between dispatch and a single ALU.
// Holds DEPTH pending ops, wakes their operands from NUM_CDB broadcast channels
// (channel 0 wins when several match) and issues one ready op per cycle into a
// valid/ready output register.
// Optional feature macro: RS_OLDEST_FIRST_EN. When defined, an age matrix picks
// the oldest ready entry; when undefined, the lowest-index ready entry issues.
module rs_multi_cdb #(
    parameter int DEPTH   = 8,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2,
    parameter int XLEN    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       rollback,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_value_1,
    input  logic [XLEN-1:0]            in_value_2,
    input  logic [ROB_W-1:0]           in_Q1,
    input  logic [ROB_W-1:0]           in_Q2,
    input  logic                       in_Q1_need,
    input  logic                       in_Q2_need,
    input  logic [XLEN-1:0]            in_value_pc,
    input  logic [XLEN-1:0]            in_imm,
    input  logic [6:0]                 in_opcode,
    input  logic [2:0]                 in_precise,
    input  logic                       in_more_precise,
    input  logic [ROB_W-1:0]           in_rob_entry,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_val,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_value_1,
    output logic [XLEN-1:0]            out_value_2,
    output logic [XLEN-1:0]            out_value_pc,
    output logic [XLEN-1:0]            out_imm,
    output logic [6:0]                 out_opcode,
    output logic [2:0]                 out_precise,
    output logic                       out_more_precise,
    output logic [ROB_W-1:0]           out_rob_entry,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Everything the ALU needs once both operands are known
    typedef struct packed {
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [6:0]       opcode;
        logic [2:0]       precise;
        logic             more;
        logic [ROB_W-1:0] rob;
    } payload_t;

    // One reservation-station slot: occupancy, pending-operand state and payload
    typedef struct packed {
        logic             valid;
        logic             need1;
        logic             need2;
        logic [ROB_W-1:0] q1;
        logic [ROB_W-1:0] q2;
        payload_t         p;
    } entry_t;

    // Returns {hit, value}; scanning downwards lets the lowest matching channel win
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [ROB_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*ROB_W-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]  vals
    );
        logic [XLEN:0] res;
        res = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (vld[c] && (tags[c*ROB_W +: ROB_W] == tag)) begin
                res = {1'b1, vals[c*XLEN +: XLEN]};
            end
        end
        return res;
    endfunction

    entry_t               ent_q [DEPTH];
    entry_t               ent_d [DEPTH];
    payload_t             out_q;
    payload_t             out_d;
    logic                 out_valid_q;
    logic                 out_valid_d;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;

    logic [DEPTH-1:0]     ready_vec;
    logic [DEPTH-1:0]     cand_vec;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     free_idx;
    logic                 accept;
    logic                 load_en;
    logic                 issue;
    logic [XLEN:0]        cap1;
    logic [XLEN:0]        cap2;
    logic [XLEN:0]        wake1 [DEPTH];
    logic [XLEN:0]        wake2 [DEPTH];
    entry_t               new_ent;

    // Dispatch credit comes only from the registered occupancy
    assign in_ready = (count_q < DEPTH_C);
    assign accept   = in_valid && in_ready;
    assign load_en  = !out_valid_q || out_ready;
    assign issue    = load_en && sel_found;

    // Same-cycle broadcast lookup for the operands of the incoming op
    assign cap1 = cdb_lookup(in_Q1, cdb_valid, cdb_tag, cdb_val);
    assign cap2 = cdb_lookup(in_Q2, cdb_valid, cdb_tag, cdb_val);

    // An entry is ready from its stored state only, so selection never sees same-edge wakeups
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = ent_q[i].valid && !ent_q[i].need1 && !ent_q[i].need2;
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // age_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    // Only the ready entry older than every other ready entry stays a candidate
    always_comb begin
        logic oldest;
        cand_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            oldest = ready_vec[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && ready_vec[j] && !age_q[i][j]) begin
                    oldest = 1'b0;
                end
            end
            cand_vec[i] = oldest;
        end
    end

    // New arrivals are younger than every live entry; freed slots leave the ordering
    always_comb begin
        age_d = age_q;
        if (rollback) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_d[i] = '0;
            end
        end else if (rdy) begin
            if (issue) begin
                age_d[sel_idx] = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    age_d[j][sel_idx] = 1'b0;
                end
            end
            if (accept) begin
                age_d[free_idx] = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    age_d[j][free_idx] = ent_q[j].valid && !(issue && (IDX_W'(j) == sel_idx));
                end
            end
        end
    end

    // Age matrix register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            age_q <= age_d;
        end
    end
`else
    // Without age tracking every ready entry competes on index alone
    always_comb cand_vec = ready_vec;
`endif

    // Lowest-index candidate wins the issue slot
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Lowest-index free slot receives the next dispatch
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Per-entry broadcast lookups for operands still waiting on a producer
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = cdb_lookup(ent_q[i].q1, cdb_valid, cdb_tag, cdb_val);
            wake2[i] = cdb_lookup(ent_q[i].q2, cdb_valid, cdb_tag, cdb_val);
        end
    end

    // Build the incoming entry, grabbing a broadcast value if its producer completes now
    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.q1       = in_Q1;
        new_ent.q2       = in_Q2;
        new_ent.p.pc     = in_value_pc;
        new_ent.p.imm    = in_imm;
        new_ent.p.opcode = in_opcode;
        new_ent.p.precise = in_precise;
        new_ent.p.more   = in_more_precise;
        new_ent.p.rob    = in_rob_entry;
        if (!in_Q1_need) begin
            new_ent.p.v1 = in_value_1;
        end else if (cap1[XLEN]) begin
            new_ent.p.v1 = cap1[XLEN-1:0];
        end else begin
            new_ent.need1 = 1'b1;
        end
        if (!in_Q2_need) begin
            new_ent.p.v2 = in_value_2;
        end else if (cap2[XLEN]) begin
            new_ent.p.v2 = cap2[XLEN-1:0];
        end else begin
            new_ent.need2 = 1'b1;
        end
    end

    // Next state: flush on rollback, otherwise wakeup, issue and dispatch while enabled
    always_comb begin
        ent_d       = ent_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        count_d     = count_q;
        if (rollback) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
            out_d       = '0;
            out_valid_d = 1'b0;
            count_d     = '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].valid && ent_q[i].need1 && wake1[i][XLEN]) begin
                    ent_d[i].need1 = 1'b0;
                    ent_d[i].p.v1  = wake1[i][XLEN-1:0];
                end
                if (ent_q[i].valid && ent_q[i].need2 && wake2[i][XLEN]) begin
                    ent_d[i].need2 = 1'b0;
                    ent_d[i].p.v2  = wake2[i][XLEN-1:0];
                end
            end
            if (load_en) begin
                if (sel_found) begin
                    out_d                = ent_q[sel_idx].p;
                    out_valid_d          = 1'b1;
                    ent_d[sel_idx].valid = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            if (accept) begin
                ent_d[free_idx] = new_ent;
            end
            count_d = count_q + CNT_W'(accept) - CNT_W'(issue);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            ent_q       <= ent_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_value_1      = out_q.v1;
    assign out_value_2      = out_q.v2;
    assign out_value_pc     = out_q.pc;
    assign out_imm          = out_q.imm;
    assign out_opcode       = out_q.opcode;
    assign out_precise      = out_q.precise;
    assign out_more_precise = out_q.more;
    assign out_rob_entry    = out_q.rob;
    assign count            = count_q;

endmodule
